iob_ext_mem_arbiter: RTL

- Two-master to one-slave IOB native-bus arbiter that shares a single external-memory port between the CPU instruction bus (master 0) and the CPU data bus (master 1).
- Sits between the external-memory halves of the ibus/dbus splits and the external memory controller, so one cache/AXI path serves both.
- One transaction is in flight at a time; each grant is held until the transaction completes.
- Arbitration is round-robin, or fixed data-priority, selected by parameter.

---
 rtl/iob_ext_mem_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/iob_ext_mem_arbiter.sv
// Shares one IOB external-memory port between instruction (m0) and data (m1) masters, one transaction at a time.
// Slave request follows the grant by 1 cycle; the granted master sees slave ready/rvalid directly, the loser waits in avalid.
module iob_ext_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cke_i,

  input  logic                  m0_avalid_i,
  input  logic [ADDR_W-1:0]     m0_addr_i,
  input  logic [DATA_W-1:0]     m0_wdata_i,
  input  logic [DATA_W/8-1:0]   m0_wstrb_i,
  output logic [DATA_W-1:0]     m0_rdata_o,
  output logic                  m0_rvalid_o,
  output logic                  m0_ready_o,

  input  logic                  m1_avalid_i,
  input  logic [ADDR_W-1:0]     m1_addr_i,
  input  logic [DATA_W-1:0]     m1_wdata_i,
  input  logic [DATA_W/8-1:0]   m1_wstrb_i,
  output logic [DATA_W-1:0]     m1_rdata_o,
  output logic                  m1_rvalid_o,
  output logic                  m1_ready_o,

  output logic                  s_avalid_o,
  output logic [ADDR_W-1:0]     s_addr_o,
  output logic [DATA_W-1:0]     s_wdata_o,
  output logic [DATA_W/8-1:0]   s_wstrb_o,
  input  logic [DATA_W-1:0]     s_rdata_i,
  input  logic                  s_rvalid_i,
  input  logic                  s_ready_i
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  typedef struct packed {
    logic              avalid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  state_t state, state_nxt;
  logic   grant, grant_nxt;
  logic   last_grant, last_grant_nxt;

  req_t   m0_req, m1_req, g_req;

  assign m0_req = {m0_avalid_i, m0_addr_i, m0_wdata_i, m0_wstrb_i};
  assign m1_req = {m1_avalid_i, m1_addr_i, m1_wdata_i, m1_wstrb_i};
  assign g_req  = grant ? m1_req : m0_req;

  // Reset wins over the clock enable so a frozen core can still be reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else if (cke_i) begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (m0_avalid_i || m1_avalid_i) begin
          state_nxt = REQ;
          if (m0_avalid_i && m1_avalid_i) begin
            grant_nxt = (ARB_MODE == 1) ? 1'b1 : ~last_grant;
          end else begin
            grant_nxt = m1_avalid_i;
          end
        end
      end
      REQ: begin
        // A master withdrawing its request aborts without touching fairness state.
        if (!g_req.avalid) begin
          state_nxt = IDLE;
        end else if (s_ready_i) begin
          last_grant_nxt = grant;
          state_nxt      = (g_req.wstrb != '0) ? IDLE : RESP;
        end
      end
      RESP: begin
        if (s_rvalid_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_avalid_o  = 1'b0;
    s_addr_o    = '0;
    s_wdata_o   = '0;
    s_wstrb_o   = '0;
    m0_ready_o  = 1'b0;
    m1_ready_o  = 1'b0;
    m0_rvalid_o = 1'b0;
    m1_rvalid_o = 1'b0;
    m0_rdata_o  = '0;
    m1_rdata_o  = '0;
    case (state)
      REQ: begin
        s_avalid_o = g_req.avalid;
        s_addr_o   = g_req.addr;
        s_wdata_o  = g_req.wdata;
        s_wstrb_o  = g_req.wstrb;
        if (g_req.avalid) begin
          if (grant) begin
            m1_ready_o = s_ready_i;
          end else begin
            m0_ready_o = s_ready_i;
          end
        end
      end
      RESP: begin
        // Only RESP forwards rvalid, so stray slave responses elsewhere are dropped.
        if (s_rvalid_i) begin
          if (grant) begin
            m1_rvalid_o = 1'b1;
            m1_rdata_o  = s_rdata_i;
          end else begin
            m0_rvalid_o = 1'b1;
            m0_rdata_o  = s_rdata_i;
          end
        end
      end
      default: ;
    endcase
  end

  a_one_ready : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(m0_ready_o && m1_ready_o));
  a_one_rvalid : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(m0_rvalid_o && m1_rvalid_o));
  a_avalid_req : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    s_avalid_o |-> (state == REQ));

endmodule
